// File: rtl/lcd_line_streamer_pkg.sv
// Shared video types, panel geometry and shade-to-RGB tables for the LCD path.
// Colour table selection lives in lcd_line_streamer (DMG_GREEN_MAP_EN).
package video_types;

  localparam int LCD_LINEWIDTH = 160;
  localparam int LCD_LINES     = 144;

  typedef logic [1:0]  Pixel;
  typedef logic [23:0] Rgb888;

  typedef enum logic {
    IDLE,
    STREAM
  } stream_state_t;

  localparam logic [3:0][23:0] GREY_TAB = {
    24'h000000,
    24'h555555,
    24'hAAAAAA,
    24'hFFFFFF
  };

  localparam logic [3:0][23:0] DMG_TAB = {
    24'h0F380F,
    24'h306230,
    24'h8BAC0F,
    24'h9BBC0F
  };

  function automatic Rgb888 shade_to_rgb(
    input Pixel             p,
    input logic [3:0][23:0] tab
  );
    return tab[p];
  endfunction

endpackage

// File: rtl/lcd_line_streamer_pingpong.sv
// Two-slot line store with write/read pointers and occupancy count.
module line_pingpong
  import video_types::*;
#(
  parameter int LINE_WIDTH = LCD_LINEWIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [2*LINE_WIDTH-1:0] wr_pixels,
  input  logic [7:0]              wr_num,
  input  logic                    rd_free,
  output logic [2*LINE_WIDTH-1:0] rd_pixels,
  output logic [7:0]              rd_num,
  output logic [1:0]              occ
);

  logic [1:0][2*LINE_WIDTH-1:0] pix_q;
  logic [1:0][7:0]              num_q;
  logic                         wr_ptr;
  logic                         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q  <= '0;
      num_q  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        pix_q[wr_ptr] <= wr_pixels;
        num_q[wr_ptr] <= wr_num;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_free) begin
        rd_ptr <= ~rd_ptr;
      end
      // simultaneous write and free leaves the count alone
      unique case ({wr_en, rd_free})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rd_pixels = pix_q[rd_ptr];
  assign rd_num    = num_q[rd_ptr];

endmodule

// File: rtl/lcd_line_streamer.sv
// Streams buffered 2-bit lines as RGB888 pixels with sol/eol/sof markers.
// Define DMG_GREEN_MAP_EN for the green palette; default is greyscale.
module lcd_line_streamer
  import video_types::*;
#(
  parameter int LINE_WIDTH = LCD_LINEWIDTH,
  parameter int NUM_LINES  = LCD_LINES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_in_valid,
  output logic                    line_in_ready,
  input  logic [7:0]              line_in_num,
  input  logic [2*LINE_WIDTH-1:0] line_in_pixels,
  output logic                    px_valid,
  input  logic                    px_ready,
  output logic [23:0]             px_data,
  output logic                    px_sol,
  output logic                    px_eol,
  output logic                    px_sof,
  output logic                    bad_line
);

`ifdef DMG_GREEN_MAP_EN
  localparam logic [3:0][23:0] SHADE_TAB = DMG_TAB;
`else
  localparam logic [3:0][23:0] SHADE_TAB = GREY_TAB;
`endif

  localparam logic [7:0] LAST_IDX = 8'(LINE_WIDTH - 1);

  stream_state_t           state;
  logic [7:0]              idx;
  logic [1:0]              occ;
  logic [2*LINE_WIDTH-1:0] rd_pixels;
  logic [7:0]              rd_num;
  logic                    accept;
  logic                    drop;
  logic                    wr_en;
  logic                    pop;
  logic                    last;
  logic                    rd_free;
  Pixel                    px_shade;

  assign line_in_ready = (occ != 2'd2);
  assign accept        = line_in_valid && line_in_ready;
  assign drop          = accept && (int'(line_in_num) >= NUM_LINES);
  assign wr_en         = accept && !drop;

  assign last    = (idx == LAST_IDX);
  assign pop     = px_valid && px_ready;
  assign rd_free = pop && last;

  line_pingpong #(
    .LINE_WIDTH(LINE_WIDTH)
  ) u_pingpong (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_pixels (line_in_pixels),
    .wr_num    (line_in_num),
    .rd_free   (rd_free),
    .rd_pixels (rd_pixels),
    .rd_num    (rd_num),
    .occ       (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 8'd0;
      bad_line <= 1'b0;
    end else begin
      if (drop) begin
        bad_line <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (pop) begin
            idx <= last ? 8'd0 : idx + 8'd1;
            // go idle only when nothing else is buffered or arriving
            if (last && occ == 2'd1 && !wr_en) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign px_shade = rd_pixels[{idx, 1'b0} +: 2];
  assign px_valid = (state == STREAM);
  assign px_sol   = px_valid && (idx == 8'd0);
  assign px_eol   = px_valid && last;
  assign px_sof   = px_sol && (rd_num == 8'd0);
  assign px_data  = px_valid ? shade_to_rgb(px_shade, SHADE_TAB) : 24'h0;

endmodule

// File: tb/tb_lcd_line_streamer.sv
// Scoreboard bench for lcd_line_streamer (greyscale build).
module tb_lcd_line_streamer;

  localparam int LW = 160;
  localparam int NL = 144;

  typedef struct {
    logic [23:0] data;
    logic        sol;
    logic        eol;
    logic        sof;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          line_in_valid = 1'b0;
  logic          line_in_ready;
  logic [7:0]    line_in_num = '0;
  logic [2*LW-1:0] line_in_pixels = '0;
  logic          px_valid;
  logic          px_ready = 1'b0;
  logic [23:0]   px_data;
  logic          px_sol;
  logic          px_eol;
  logic          px_sof;
  logic          bad_line;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rmode = 0;
  bit   mon_en = 1'b0;

  lcd_line_streamer #(
    .LINE_WIDTH(LW),
    .NUM_LINES (NL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_in_valid (line_in_valid),
    .line_in_ready (line_in_ready),
    .line_in_num   (line_in_num),
    .line_in_pixels(line_in_pixels),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_data       (px_data),
    .px_sol        (px_sol),
    .px_eol        (px_eol),
    .px_sof        (px_sof),
    .bad_line      (bad_line)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] grey(input logic [1:0] s);
    case (s)
      2'd0:    return 24'hFFFFFF;
      2'd1:    return 24'hAAAAAA;
      2'd2:    return 24'h555555;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [2*LW-1:0] make_line(input int mode);
    logic [2*LW-1:0] v;
    logic [7:0]      b;
    logic [1:0]      s;
    v = '0;
    for (int i = 0; i < LW; i++) begin
      b = 8'(i);
      case (mode)
        0:       s = 2'd2;
        1:       s = b[1:0] ^ b[3:2] ^ b[5:4];
        2:       s = b[2:1];
        default: s = ~b[1:0] ^ b[7:6];
      endcase
      v[2*i +: 2] = s;
    end
    return v;
  endfunction

  task automatic push_line(input logic [7:0] num, input logic [2*LW-1:0] pix);
    exp_t e;
    for (int i = 0; i < LW; i++) begin
      e.data = grey(pix[2*i +: 2]);
      e.sol  = (i == 0);
      e.eol  = (i == LW - 1);
      e.sof  = (i == 0) && (num == 8'd0);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, req);
    end
  endtask

  task automatic chkn(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       px_ready = 1'b0;
        1:       px_ready = 1'b1;
        default: px_ready = ~px_ready;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (exp_q.size() != 0) begin
        if (!px_valid) begin
          errors++;
          $display("FAIL px_valid_gap: got 0 want 1 (%0d pending)",
                   exp_q.size());
        end else begin
          e = exp_q[0];
          if ({px_data, px_sol, px_eol, px_sof} !==
              {e.data, e.sol, e.eol, e.sof}) begin
            errors++;
            $display("FAIL pixel: got %h s%0b e%0b f%0b want %h s%0b e%0b f%0b",
                     px_data, px_sol, px_eol, px_sof,
                     e.data, e.sol, e.eol, e.sof);
          end
          if (px_ready) void'(exp_q.pop_front());
        end
      end else if (px_valid) begin
        errors++;
        $display("FAIL unexpected_pixel: got valid %h want none", px_data);
      end
    end
  end

  task automatic wait_accept(input logic [7:0] num, input logic [2*LW-1:0] pix,
                             input bit at_sol);
    int n;
    n = 0;
    while (!line_in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_timeout", line_in_ready, 1'b1);
    if (line_in_ready) begin
      if (at_sol) begin
        chk1("ready_at_line2_sol", px_sol, 1'b1);
        #1;
        chkn("ready_remaining", exp_q.size(), LW - 1);
      end
      @(posedge clk);
      #1;
      if (num < NL) push_line(num, pix);
    end
    line_in_valid = 1'b0;
  endtask

  task automatic offer(input logic [7:0] num, input logic [2*LW-1:0] pix);
    @(negedge clk);
    line_in_valid  = 1'b1;
    line_in_num    = num;
    line_in_pixels = pix;
    wait_accept(num, pix, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chkn("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk1("idle_valid", px_valid, 1'b0);
  endtask

  task automatic check_reset_state();
    chk1("rst_px_valid", px_valid, 1'b0);
    chk1("rst_ready", line_in_ready, 1'b1);
    chkn("rst_px_data", int'(px_data), 0);
    chk1("rst_sol", px_sol, 1'b0);
    chk1("rst_eol", px_eol, 1'b0);
    chk1("rst_sof", px_sof, 1'b0);
    chk1("rst_bad_line", bad_line, 1'b0);
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    mon_en = 1'b1;

    // single grey line, ready high
    rmode = 1;
    offer(8'd5, make_line(0));
    drain();

    // ready toggling, two lines
    rmode = 2;
    offer(8'd7, make_line(1));
    offer(8'd8, make_line(2));
    drain();

    // three lines with sink stalled
    rmode = 0;
    offer(8'd1, make_line(1));
    offer(8'd2, make_line(2));
    @(negedge clk);
    line_in_valid  = 1'b1;
    line_in_num    = 8'd3;
    line_in_pixels = make_line(3);
    for (int i = 0; i < 4; i++) begin
      chk1("line3_blocked", line_in_ready, 1'b0);
      @(negedge clk);
    end
    rmode = 1;
    wait_accept(8'd3, make_line(3), 1'b1);
    drain();

    // line 0 then out-of-range line 144
    offer(8'd0, make_line(3));
    offer(8'd144, make_line(1));
    drain();
    chk1("bad_line_set", bad_line, 1'b1);
    offer(8'd9, make_line(2));
    drain();
    chk1("bad_line_sticky", bad_line, 1'b1);

    // accept on the final-pixel pop
    offer(8'd20, make_line(1));
    n = 0;
    while (!(px_valid && px_eol) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1("eol_timeout", px_eol, 1'b1);
    line_in_valid  = 1'b1;
    line_in_num    = 8'd21;
    line_in_pixels = make_line(2);
    wait_accept(8'd21, make_line(2), 1'b0);
    @(negedge clk);
    chk1("nobubble_valid", px_valid, 1'b1);
    chk1("nobubble_sol", px_sol, 1'b1);
    drain();

    // reset mid-line with a second line queued
    offer(8'd30, make_line(1));
    offer(8'd31, make_line(2));
    n = 0;
    while (exp_q.size() > 2*LW - 80 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chkn("reach_px80", exp_q.size(), 2*LW - 80);
    chk1("pre_reset_bad_line", bad_line, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state();
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (px_valid) seen++;
    end
    chkn("post_reset_pixels", seen, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_line_streamer.md
LCD_LINE_STREAMER -- requirements
Module: lcd_line_streamer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 160, meaning pixels per rendered line.
REQ-002 SHALL have parameter NUM_LINES, default 144, meaning visible lines per frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, one clock; reset is synchronous and active-high.
REQ-005 SHALL have port line_in_valid, input, 1, renderer offers a completed line.
REQ-006 SHALL have port line_in_ready, output, 1, a line buffer slot is free.
REQ-007 SHALL have port line_in_num, input, 8, line number of the offered line.
REQ-008 SHALL have port line_in_pixels, input, 2*LINE_WIDTH, pixel i in bits [2i+1:2i].
REQ-009 SHALL have port px_valid, output, 1, px_data holds a valid pixel.
REQ-010 SHALL have port px_ready, input, 1, sink accepts the pixel.
REQ-011 SHALL have port px_data, output, 24, RGB888 pixel.
REQ-012 SHALL have ports px_sol, px_eol, px_sof, output, 1 each; start of line, end of line, start of frame, qualified by px_valid.
REQ-013 SHALL have port bad_line, output, 1, sticky: a line with line_in_num >= NUM_LINES was offered.

Function
REQ-014 SHALL hold two line slots (ping-pong); line_in_ready = 1 when fewer than 2 slots are occupied.
REQ-015 SHALL capture line_in_pixels and line_in_num into the write slot when line_in_valid && line_in_ready.
REQ-016 SHALL drop an offered line with line_in_num >= NUM_LINES: the handshake completes, no slot is written, and bad_line is set.
REQ-017 SHALL use states IDLE (no occupied slot) and STREAM (read slot occupied); IDLE->STREAM on occupancy > 0; STREAM->IDLE after the last pixel pops with no other slot occupied.
REQ-018 SHALL assert px_valid on the cycle after a line is accepted into an empty buffer (1-cycle latency).
REQ-019 SHALL pop a pixel when px_valid && px_ready and advance the 8-bit pixel index; at index LINE_WIDTH-1 the index wraps to 0, the slot is freed and the read pointer toggles.
REQ-020 SHALL keep px_data and all markers stable while px_valid && !px_ready.
REQ-021 SHALL assert px_sol at index 0, px_eol at index LINE_WIDTH-1, and px_sof at index 0 of a line whose number is 0.
REQ-022 SHALL, on a simultaneous accept and final-pixel pop, perform both in the same cycle with occupancy unchanged; the next line streams with no bubble.
REQ-023 SHALL stream back-to-back slots with no idle cycle when px_ready is held high.

Reset
REQ-024 SHALL on reset clear both slots, pointers, pixel index and bad_line, enter IDLE, and drive px_valid=0, px_sol=px_eol=px_sof=0, px_data=0, line_in_ready=1 on the following cycle.
REQ-025 SHALL discard any line mid-stream on reset; no further pixel from that line appears.

Configuration
REQ-026 SHALL, with DMG_GREEN_MAP_EN defined, map shades 0..3 to 0x9BBC0F, 0x8BAC0F, 0x306230, 0x0F380F.
REQ-027 SHALL, without DMG_GREEN_MAP_EN, map shades 0..3 to greys 0xFFFFFF, 0xAAAAAA, 0x555555, 0x000000.

Structure
REQ-028 SHALL take LCD_LINEWIDTH, LCD_LINES, the Pixel type and a new Rgb888 typedef plus both shade tables from package video_types.
REQ-029 SHALL implement the two-slot storage and pointers as sub-module line_pingpong; the FSM, index counter and colour map stay in lcd_line_streamer.

Verification
REQ-030 SHALL cover: one line of all shade 2, line_num 5, px_ready=1 -> px_valid the next cycle, 160 pixels of 0x555555 (grey build), px_sol on the first, px_eol on the last, no px_sof.
REQ-031 SHALL cover: three lines offered back-to-back, px_ready=0 -> lines 1-2 accepted, line_in_ready=0 for line 3 until the first pixel of line 2 is popped after line 1 drains.
REQ-032 SHALL cover: px_ready toggling every cycle -> px_data/markers stable while stalled, exactly 160 pops per line, order pixel 0..159.
REQ-033 SHALL cover: line_num 0 then line_num 144 -> px_sof on the first pixel of line 0, line 144 dropped, bad_line=1 and remains 1 until reset.
REQ-034 SHALL cover: reset asserted at pixel 80 of a line with a second line queued -> px_valid=0 the next cycle, line_in_ready=1, no further pixels emitted.
REQ-035 SHALL cover: accept on the same cycle as the final-pixel pop -> pixel 0 of the new line follows pixel 159 on the very next cycle.
